// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 8-to-1 data mux.
// Optional forced-release hold timeout is built when MUX_ARB_TIMEOUT_EN is defined.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_req,
    input  logic       i_done,
    output logic [2:0] o_sel,
    output logic [7:0] o_grant,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_hold_range
        $error("mux_sel_arbiter: MAX_HOLD must be in 2..256");
    end

    state_e     r_state;
    state_e     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] r_sel;
    logic [7:0] r_grant;
    logic       r_busy;
    logic       r_timeout;

    logic [2:0] w_ptr_nxt;
    logic [2:0] w_sel_nxt;
    logic [7:0] w_grant_nxt;
    logic       w_busy_nxt;
    logic       w_timeout_nxt;

    logic [2:0] w_pick;
    logic       w_any;
    logic       w_owner_req;
    logic       w_fire;
    logic       w_release;

    // First requester at or after the priority pointer, wrapping modulo 8.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!w_any && i_req[r_ptr + 3'(i)]) begin
                w_any  = 1'b1;
                w_pick = r_ptr + 3'(i);
            end
        end
    end

    // r_sel always holds the current owner's index while in GRANT.
    assign w_owner_req = i_req[r_sel];

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 8'd0;
        end else if (r_state == StIdle) begin
            r_hold <= 8'd0;
        end else begin
            r_hold <= r_hold + 8'd1;
        end
    end

    // Forced release only when the owner would otherwise keep the mux.
    assign w_fire = (r_state == StGrant) && !i_done && w_owner_req && (r_hold == HoldLast);
`else
    assign w_fire = 1'b0;
`endif

    assign w_release = (r_state == StGrant) && (i_done || !w_owner_req || w_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_any)     w_state_nxt = StGrant;
            StGrant: if (w_release) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Next values of the registered outputs and the priority pointer.
    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_grant_nxt = 8'b1 << w_pick;
                    w_sel_nxt   = w_pick;
                    w_busy_nxt  = 1'b1;
                end
            end
            StGrant: begin
                if (w_release) begin
                    w_grant_nxt   = 8'd0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = r_sel + 3'd1;
                    w_timeout_nxt = w_fire;
                end
            end
            default: begin
                w_grant_nxt = 8'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 3'd0;
            r_sel     <= 3'd0;
            r_grant   <= 8'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_sel     <= w_sel_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_sel     = r_sel;
    assign o_grant   = r_grant;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed-vector bench for mux_sel_arbiter; define MUX_ARB_TIMEOUT_EN to check the timeout build.
module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    int n_vec;
    int n_bad;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    mux_sel_arbiter #(
        .MAX_HOLD (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req),
        .i_done    (done),
        .o_sel     (sel),
        .o_grant   (grant),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] rq, input logic d,
                       input logic [7:0] g, input logic [2:0] s, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.grant = g; v.sel = s; v.busy = b;
        vecs.push_back(v);
    endtask

    // Compares {grant, sel, busy, timeout} against the expected tuple.
    task automatic check(input string name, input logic [7:0] g, input logic [2:0] s,
                         input logic b, input logic t);
        n_vec++;
        if ({grant, sel, busy, timeout} !== {g, s, b, t}) begin
            n_bad++;
            $display("FAIL %s: got grant=%h sel=%0d busy=%b timeout=%b, want grant=%h sel=%0d busy=%b timeout=%b",
                     name, grant, sel, busy, timeout, g, s, b, t);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        check("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        step();
        check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 8'h00, 3'd0, 0);
        // Two requesters, pointer moves past the first owner.
        add(0, 8'h24, 0, 8'h04, 3'd2, 1);
        add(0, 8'h24, 1, 8'h00, 3'd2, 0);
        add(0, 8'h24, 0, 8'h20, 3'd5, 1);
        add(0, 8'h24, 1, 8'h00, 3'd5, 0);
        add(0, 8'h00, 0, 8'h00, 3'd5, 0);
        // Reset, then full round-robin sweep with wrap back to 0.
        add(1, 8'hFF, 0, 8'h00, 3'd0, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 8'hFF, 0, 8'h01 << k, 3'(k), 1);
            add(0, 8'hFF, 1, 8'h00, 3'(k), 0);
        end
        add(0, 8'hFF, 0, 8'h01, 3'd0, 1);
        add(0, 8'hFF, 1, 8'h00, 3'd0, 0);
        // Owner 3 drops its request; other bits ignored during GRANT.
        add(0, 8'h08, 0, 8'h08, 3'd3, 1);
        add(0, 8'h0F, 0, 8'h08, 3'd3, 1);
        add(0, 8'h01, 0, 8'h00, 3'd3, 0);
        add(0, 8'h09, 0, 8'h01, 3'd0, 1);
        add(0, 8'h09, 1, 8'h00, 3'd0, 0);
        // done is ignored while idle.
        add(0, 8'h00, 1, 8'h00, 3'd0, 0);
        add(0, 8'h09, 1, 8'h08, 3'd3, 1);
        add(0, 8'h09, 1, 8'h00, 3'd3, 0);
        add(0, 8'h00, 0, 8'h00, 3'd3, 0);

        foreach (vecs[i]) begin
            req   = vecs[i].req;
            done  = vecs[i].done;
            rst_n = !vecs[i].rst;
            step();
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy, 1'b0);
            rst_n = 1'b1;
        end

        // Hold with done low: forced release after 4 cycles only in the timeout build.
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 8'h01;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (ToEn && c == 5) check($sformatf("hold_c%0d", c), 8'h00, 3'd0, 1'b0, 1'b1);
            else                check($sformatf("hold_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        req = 8'h00;
        step();
        check("hold_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Advance the pointer, grant owner 6, then reset mid-grant.
        req = 8'h08;
        step();
        check("pre_rst_g3", 8'h08, 3'd3, 1'b1, 1'b0);
        done = 1'b1;
        step();
        check("pre_rst_rel", 8'h00, 3'd3, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h40;
        step();
        check("owner6", 8'h40, 3'd6, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_grant_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        req   = 8'h41;
        step();
        check("post_rst_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
